// File: rtl/ps2_rx_if.sv
// Byte stream from the PS/2 receiver FIFO to its consumer.
// Valid/ready handshake: a byte moves when both are high on a rising clock edge.
interface ps2_rx_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, out_valid, input  out_ready);
   modport slave  (input  out_data, out_valid, output out_ready);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronize and deglitch both lines, deframe
// 11-bit frames on filtered falling clock edges, and buffer good bytes in a FIFO.
module ps2_rx #(
   parameter int FILTER_LEN = 4,
   parameter int TIMEOUT    = 2000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     ps2_clk,
   input  logic     ps2_dat,
   ps2_rx_if.master stream,
   output logic     parity_err,
   output logic     frame_err,
   output logic     overflow
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Index 0 is the clock line, index 1 the data line.
   logic [1:0]         s1, s2, filt;
   logic [1:0][FW-1:0] fcnt;
   logic               clk_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1       <= '1;
         s2       <= '1;
         filt     <= '1;
         fcnt     <= '0;
         clk_prev <= 1'b1;
      end else begin
         s1       <= {ps2_dat, ps2_clk};
         s2       <= s1;
         clk_prev <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
               filt[i] <= s2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   wire fall = clk_prev & ~filt[0];
   wire bit_in = filt[1];

   state_t        state;
   logic [2:0]    bcnt;
   logic [TW-1:0] tmo;
   logic [7:0]    shreg;
   logic          par_bit;

   wire par_ok = ^{shreg, par_bit};
   wire push   = fall && (state == STOP) && bit_in && par_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bcnt       <= '0;
         tmo        <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         tmo        <= (state == IDLE || fall) ? '0 : tmo + 1'b1;
         // A stalled device leaves the frame half-done; abandon it silently except for frame_err.
         if (state != IDLE && !fall && tmo == TW'(TIMEOUT - 1)) begin
            state     <= IDLE;
            tmo       <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: if (!bit_in) begin
                  state <= DATA;
                  bcnt  <= '0;
                  shreg <= '0;
               end
               DATA: begin
                  shreg[bcnt] <= bit_in;
                  bcnt        <= bcnt + 1'b1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
                  par_bit <= bit_in;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (!bit_in)      frame_err  <= 1'b1;
                  else if (!par_ok) parity_err <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   occ;

   wire full = (occ == (AW + 1)'(FIFO_DEPTH));
   wire pop  = stream.out_valid && stream.out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   wire wr   = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         occ      <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= push && full && !pop;
         if (wr)  wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         occ <= occ + (AW + 1)'(wr) - (AW + 1)'(pop);
      end
   end

   assign stream.out_valid = (occ != '0);
   assign stream.out_data  = stream.out_valid ? mem[rp] : 8'h00;
endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive identical synchronized samples required before a filtered line changes.
REQ-002 Parameter TIMEOUT, default 2000: idle clk cycles between falling edges that abort a frame in progress.
REQ-003 Parameter FIFO_DEPTH, default 4, power of two >= 2: output byte buffer depth.
REQ-004 clk  input  1  system clock; the block SHALL use this one clock only, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ps2_clk  input  1  asynchronous serial clock from device; idles high.
REQ-007 ps2_dat  input  1  asynchronous serial data from device; idles high.
REQ-008 out_data  output  8  head-of-FIFO received byte.
REQ-009 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid and out_ready are both high.
REQ-011 parity_err  output  1  one-cycle pulse: frame dropped, bad parity.
REQ-012 frame_err  output  1  one-cycle pulse: frame dropped, bad stop bit or timeout.
REQ-013 overflow  output  1  one-cycle pulse: good byte dropped, FIFO full.

Function
REQ-014 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer, then a filter that changes its output only after FILTER_LEN equal consecutive synchronized samples; both filtered lines reset to 1.
REQ-015 A falling edge is filtered clock 1 in the previous cycle and 0 in the current cycle; filtered data SHALL be sampled in that same cycle.
REQ-016 Frame format: start 0, eight data bits LSB first, odd parity (XOR of data and parity = 1), stop 1.
REQ-017 FSM states: IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: edge with data 0 -> DATA, bit count = 0; edge with data 1 -> stay IDLE, no error pulse.
REQ-019 DATA: each edge shifts the sampled bit into bit[count], count+1; after the 8th bit -> PARITY.
REQ-020 PARITY: edge stores the parity bit -> STOP.
REQ-021 STOP: edge -> IDLE; stop 0 -> frame_err; stop 1 with bad parity -> parity_err; stop 1 with good parity -> push byte.
REQ-022 A bad stop bit SHALL take priority over bad parity; exactly one error pulse per frame.
REQ-023 Timeout counter clears on every falling edge and in IDLE; in any other state, reaching TIMEOUT SHALL force IDLE, discard the partial byte and pulse frame_err.
REQ-024 Latency: with the stop edge in cycle N, the FIFO write and any error pulse SHALL occur at the clock edge ending cycle N; out_valid is high in cycle N+1 if the FIFO was empty.
REQ-025 Pop occurs when out_valid and out_ready are high; out_data then shows the next entry in the following cycle.
REQ-026 Push with FIFO full and no pop in the same cycle SHALL drop the new byte and pulse overflow; stored contents are unchanged.
REQ-027 Push with FIFO full and a pop in the same cycle SHALL succeed; occupancy is unchanged and no overflow pulse occurs.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order is strictly first-in, first-out.
REQ-029 out_data SHALL be held stable while out_valid is high and out_ready is low.

Reset
REQ-030 While reset is high: FSM IDLE, count 0, timeout 0, FIFO empty, synchronizers and filters 1.
REQ-031 While reset is high, outputs SHALL be out_valid 0, out_data 8'h00, all pulse outputs 0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame with no error pulse; the next frame after release is received normally.

Verification
REQ-033 Frames 0x00..0x0F sent at 80 us bit period with out_ready held high -> 16 bytes delivered in order, no error pulses.
REQ-034 Frame 0xA5 with parity bit 0 (wrong) -> single parity_err pulse, out_valid stays 0.
REQ-035 Frame 0x3C with stop bit 0 -> single frame_err pulse; a following good 0x3D is delivered.
REQ-036 out_ready low, FIFO_DEPTH+1 frames 0x10..0x14 -> overflow pulses once, FIFO holds 0x10..0x13; draining pops those four bytes in order.
REQ-037 ps2_clk stopped after 4 data bits for more than TIMEOUT cycles -> frame_err pulse, FSM IDLE; next frame 0x55 received correctly.
REQ-038 1-cycle glitches on ps2_clk mid-frame with FILTER_LEN=4 -> no extra bit captured; byte correct; reset pulsed mid-frame -> no output, no error.
